// File: rtl/ahb_spi_master.sv
// AHB-Lite slave fronting a mode-0, MSB-first SPI master with TX/RX byte FIFOs.
// Optional feature macro: SPI_IRQ_EN adds the IRQEN register and the IRQ output.
module ahb_spi_master #(
    parameter int         FIFO_DEPTH = 8,
    parameter logic [7:0] DIV_RST    = 8'd4
) (
    input  logic        HCLK,
    input  logic        HRESETN,
    input  logic        HSEL,
    input  logic [4:0]  HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADYIN,
    output logic [31:0] HRDATA,
    output logic        HREADY,
    output logic [1:0]  HRESP,
    output logic        SPISCLKO,
    output logic        SPISDO,
    output logic        SPISS,
    input  logic        SPISDI
`ifdef SPI_IRQ_EN
    ,
    output logic        IRQ
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    localparam logic [2:0] A_CTRL  = 3'd0;
    localparam logic [2:0] A_STAT  = 3'd1;
    localparam logic [2:0] A_TX    = 3'd2;
    localparam logic [2:0] A_RX    = 3'd3;
`ifdef SPI_IRQ_EN
    localparam logic [2:0] A_IRQEN = 3'd4;
`endif

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_LOW  = 3'd2;
    localparam logic [2:0] S_HIGH = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic        sel_q, wr_q;
    logic [2:0]  addr_q;
    logic        en_q, ss_q, rxovf_q;
    logic [7:0]  clkdiv_q;

    logic [7:0]  tx_mem_q [FIFO_DEPTH];
    logic [7:0]  rx_mem_q [FIFO_DEPTH];
    logic [AW:0] tx_wptr_q, tx_rptr_q, rx_wptr_q, rx_rptr_q;

    logic [2:0]  state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic        sclk_q, sclk_d;
    logic        sdo_q, sdo_d;
    logic [7:0]  shreg_q, shreg_d;

    logic        bus_wr, bus_rd;
    logic        tx_empty, tx_full, rx_empty, rx_full;
    logic        tx_push, tx_pop, rx_push, rx_pop, rx_ovf_set;
    logic        busy;
    logic [31:0] rdata;

    logic        unused_bits;
    assign unused_bits = ^{HSIZE, HADDR[1:0], HTRANS[0], HWDATA[31:16]};

    assign HREADY   = 1'b1;
    assign HRESP    = 2'b00;
    assign SPISCLKO = sclk_q;
    assign SPISDO   = sdo_q;
    assign SPISS    = ~ss_q;

    // Address phase is captured here; the data phase acts on the next cycle.
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            sel_q  <= 1'b0;
            wr_q   <= 1'b0;
            addr_q <= 3'd0;
        end else if (HSEL && HTRANS[1] && HREADYIN) begin
            sel_q  <= 1'b1;
            wr_q   <= HWRITE;
            addr_q <= HADDR[4:2];
        end else begin
            sel_q  <= 1'b0;
        end
    end

    assign bus_wr = sel_q & wr_q;
    assign bus_rd = sel_q & ~wr_q;

    assign tx_empty = (tx_wptr_q == tx_rptr_q);
    assign tx_full  = (tx_wptr_q[AW] != tx_rptr_q[AW]) &&
                      (tx_wptr_q[AW-1:0] == tx_rptr_q[AW-1:0]);
    assign rx_empty = (rx_wptr_q == rx_rptr_q);
    assign rx_full  = (rx_wptr_q[AW] != rx_rptr_q[AW]) &&
                      (rx_wptr_q[AW-1:0] == rx_rptr_q[AW-1:0]);

    // A simultaneous pop frees the slot, so a push into a full FIFO is accepted then.
    assign tx_pop     = (state_q == S_LOAD);
    assign tx_push    = bus_wr && (addr_q == A_TX) && (!tx_full || tx_pop);
    assign rx_pop     = bus_rd && (addr_q == A_RX) && !rx_empty;
    assign rx_push    = (state_q == S_DONE) && (!rx_full || rx_pop);
    assign rx_ovf_set = (state_q == S_DONE) && rx_full && !rx_pop;

    assign busy = (state_q != S_IDLE) | ~tx_empty;

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
        end else begin
            if (tx_push) tx_wptr_q <= tx_wptr_q + PTR_ONE;
            if (tx_pop)  tx_rptr_q <= tx_rptr_q + PTR_ONE;
            if (rx_push) rx_wptr_q <= rx_wptr_q + PTR_ONE;
            if (rx_pop)  rx_rptr_q <= rx_rptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge HCLK) begin
        if (tx_push) tx_mem_q[tx_wptr_q[AW-1:0]] <= HWDATA[7:0];
        if (rx_push) rx_mem_q[rx_wptr_q[AW-1:0]] <= shreg_q;
    end

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            en_q     <= 1'b0;
            ss_q     <= 1'b0;
            clkdiv_q <= DIV_RST;
            rxovf_q  <= 1'b0;
        end else begin
            if (bus_wr && addr_q == A_CTRL) begin
                en_q     <= HWDATA[0];
                ss_q     <= HWDATA[1];
                clkdiv_q <= HWDATA[15:8];
            end
            if (rx_ovf_set)
                rxovf_q <= 1'b1;
            else if (bus_wr && addr_q == A_STAT && HWDATA[5])
                rxovf_q <= 1'b0;
        end
    end

    // Shift engine: each half-period lasts clkdiv+1 cycles; MISO is sampled on the rising SCLK.
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bitcnt_d = bitcnt_q;
        sclk_d   = sclk_q;
        sdo_d    = sdo_q;
        shreg_d  = shreg_q;
        case (state_q)
            S_IDLE: begin
                if (en_q && !tx_empty) state_d = S_LOAD;
            end
            S_LOAD: begin
                shreg_d  = tx_mem_q[tx_rptr_q[AW-1:0]];
                sdo_d    = shreg_d[7];
                bitcnt_d = 3'd7;
                div_d    = 8'd0;
                state_d  = S_LOW;
            end
            S_LOW: begin
                if (div_q >= clkdiv_q) begin
                    div_d   = 8'd0;
                    sclk_d  = 1'b1;
                    shreg_d = {shreg_q[6:0], SPISDI};
                    state_d = S_HIGH;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            S_HIGH: begin
                if (div_q >= clkdiv_q) begin
                    div_d  = 8'd0;
                    sclk_d = 1'b0;
                    if (bitcnt_q == 3'd0) begin
                        state_d = S_DONE;
                    end else begin
                        bitcnt_d = bitcnt_q - 3'd1;
                        sdo_d    = shreg_q[7];
                        state_d  = S_LOW;
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            state_q  <= S_IDLE;
            div_q    <= 8'd0;
            bitcnt_q <= 3'd0;
            sclk_q   <= 1'b0;
            sdo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bitcnt_q <= bitcnt_d;
            sclk_q   <= sclk_d;
            sdo_q    <= sdo_d;
        end
    end

    always_ff @(posedge HCLK) begin
        shreg_q <= shreg_d;
    end

`ifdef SPI_IRQ_EN
    logic [1:0] irqen_q;
    logic       irq_q;

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            irqen_q <= 2'b00;
            irq_q   <= 1'b0;
        end else begin
            if (bus_wr && addr_q == A_IRQEN) irqen_q <= HWDATA[1:0];
            irq_q <= (irqen_q[0] & tx_empty & (state_q == S_IDLE)) |
                     (irqen_q[1] & ~rx_empty) | rxovf_q;
        end
    end

    assign IRQ = irq_q;
`endif

    always_comb begin
        rdata = 32'd0;
        if (bus_rd) begin
            case (addr_q)
                A_CTRL: rdata = {16'd0, clkdiv_q, 6'd0, ss_q, en_q};
                A_STAT: rdata = {26'd0, rxovf_q, busy, rx_empty, rx_full, tx_empty, tx_full};
                A_RX:   if (!rx_empty) rdata = {24'd0, rx_mem_q[rx_rptr_q[AW-1:0]]};
`ifdef SPI_IRQ_EN
                A_IRQEN: rdata = {30'd0, irqen_q};
`endif
                default: rdata = 32'd0;
            endcase
        end
    end

    assign HRDATA = rdata;

endmodule

// File: tb/tb_ahb_spi_master.sv
// Directed bench for ahb_spi_master; bus reads are checked by a scoreboard monitor, SDO looped to SDI.
module tb_ahb_spi_master;

    localparam logic [4:0] R_CTRL  = 5'h00;
    localparam logic [4:0] R_STAT  = 5'h04;
    localparam logic [4:0] R_TX    = 5'h08;
    localparam logic [4:0] R_RX    = 5'h0C;
    localparam logic [4:0] R_IRQEN = 5'h10;

    logic        HCLK = 1'b0;
    logic        HRESETN;
    logic        HSEL;
    logic [4:0]  HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADYIN;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic [1:0]  HRESP;
    logic        SPISCLKO, SPISDO, SPISS, SPISDI;
`ifdef SPI_IRQ_EN
    logic        IRQ;
`endif

    int checks = 0;
    int errors = 0;
    int sclk_edges = 0;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] exp;
    } sb_t;
    sb_t  sb_q[$];
    sb_t  mon_e;
    logic rd_dphase;

    assign SPISDI = SPISDO;

    always #5 HCLK = ~HCLK;

    ahb_spi_master dut (
        .HCLK(HCLK), .HRESETN(HRESETN), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADYIN(HREADYIN),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .SPISCLKO(SPISCLKO),
        .SPISDO(SPISDO), .SPISS(SPISS), .SPISDI(SPISDI)
`ifdef SPI_IRQ_EN
        , .IRQ(IRQ)
`endif
    );

    always @(posedge SPISCLKO) sclk_edges <= sclk_edges + 1;

    always @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) rd_dphase <= 1'b0;
        else          rd_dphase <= HSEL && HTRANS[1] && !HWRITE && HREADYIN;
    end

    // Scoreboard monitor: one expectation per read data phase.
    always @(negedge HCLK) begin
        if (rd_dphase) begin
            checks = checks + 1;
            if (sb_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL sb_unexpected_read: HRDATA=0x%0h with no expectation queued", HRDATA);
            end else begin
                mon_e = sb_q.pop_front();
                if (HRDATA !== mon_e.exp) begin
                    errors = errors + 1;
                    $display("FAIL read_0x%02h: got 0x%0h expected 0x%0h", mon_e.addr, HRDATA, mon_e.exp);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic ahb_write(input logic [4:0] a, input logic [31:0] d);
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
    endtask

    task automatic ahb_read_now(input logic [4:0] a, input logic [31:0] exp);
        sb_t e;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
        e.addr = a; e.exp = exp;
        sb_q.push_back(e);
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
    endtask

    task automatic ahb_read(input logic [4:0] a, input logic [31:0] exp);
        @(posedge HCLK); #1;
        ahb_read_now(a, exp);
    endtask

    task automatic spi_capture(output logic [7:0] b);
        int t;
        int hi;
        t = 0;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            while (SPISCLKO !== 1'b1 && t < 4000) begin @(negedge HCLK); t++; end
            b[7-i] = SPISDO;
            hi = 0;
            while (SPISCLKO === 1'b1 && t < 4000) begin hi++; @(negedge HCLK); t++; end
            check($sformatf("t2_sclk_high_len_bit%0d", i), hi, 5);
        end
        check("t2_capture_in_time", (t < 4000) ? 1 : 0, 1);
    endtask

    // Issue a RXDATA read whose data phase coincides with the DONE cycle (CLKDIV=0).
    task automatic t5_sync_read(input logic [31:0] exp);
        int   n;
        int   t;
        logic prev;
        n = 0; t = 0; prev = SPISCLKO;
        while (n < 8 && t < 500) begin
            @(negedge HCLK); t++;
            if (SPISCLKO && !prev) n++;
            prev = SPISCLKO;
        end
        check("t5_sclk_rises_seen", n, 8);
        ahb_read_now(R_RX, exp);
    endtask

    initial begin
        logic [7:0] cap;
        int         t;
        HRESETN = 1'b0; HSEL = 1'b0; HADDR = 5'd0; HTRANS = 2'b00; HWRITE = 1'b0;
        HSIZE = 3'b010; HWDATA = 32'd0; HREADYIN = 1'b1;
        repeat (3) @(negedge HCLK);
        HRESETN = 1'b1;

        // T1 reset values
        check("rst_spiss", SPISS, 1);
        check("rst_sclk", SPISCLKO, 0);
        check("rst_sdo", SPISDO, 0);
        check("rst_hrdata", HRDATA, 0);
        check("hready", HREADY, 1);
        check("hresp", HRESP, 0);
`ifdef SPI_IRQ_EN
        check("rst_irq", IRQ, 0);
`endif
        ahb_read(R_CTRL, 32'h0400);
        ahb_read(R_STAT, 32'h0A);
        ahb_read(R_TX, 32'h0);
        ahb_read(R_RX, 32'h0);
        ahb_read(R_IRQEN, 32'h0);
        ahb_read(5'h14, 32'h0);
        ahb_read(5'h1C, 32'h0);

        // T2 single byte, CLKDIV=4
        ahb_write(R_CTRL, 32'h0403);
        ahb_read(R_CTRL, 32'h0403);
        check("t2_spiss_low", SPISS, 0);
        ahb_write(R_TX, 32'hA5);
        spi_capture(cap);
        check("t2_sdo_bits", cap, 8'hA5);
        repeat (4) @(posedge HCLK);
        ahb_read(R_RX, 32'hA5);
        ahb_read(R_STAT, 32'h0A);

        // T3 fill TX with EN=0, ninth write dropped
        ahb_write(R_CTRL, 32'h0002);
        for (int i = 0; i < 9; i++) ahb_write(R_TX, 32'h10 + i);
        ahb_read(R_STAT, 32'h19);
        t = sclk_edges;
        ahb_write(R_CTRL, 32'h0003);
        repeat (300) @(posedge HCLK);
        check("t3_sclk_edges", sclk_edges - t, 64);
        ahb_read(R_STAT, 32'h06);
        for (int i = 0; i < 8; i++) ahb_read(R_RX, 32'h10 + i);
        ahb_read(R_RX, 32'h0);
        ahb_read(R_STAT, 32'h0A);

        // T4 RX overflow and W1C clear
        for (int i = 0; i < 9; i++) ahb_write(R_TX, 32'h30 + i);
        repeat (300) @(posedge HCLK);
        ahb_read(R_STAT, 32'h26);
        for (int i = 0; i < 8; i++) ahb_read(R_RX, 32'h30 + i);
        ahb_read(R_STAT, 32'h2A);
        ahb_write(R_STAT, 32'h20);
        ahb_read(R_STAT, 32'h0A);

        // T5 pop and push on the same cycle with RX full
        for (int i = 0; i < 8; i++) ahb_write(R_TX, 32'h40 + i);
        repeat (250) @(posedge HCLK);
        ahb_read(R_STAT, 32'h06);
        ahb_write(R_TX, 32'h48);
        t5_sync_read(32'h40);
        repeat (5) @(posedge HCLK);
        ahb_read(R_STAT, 32'h06);
        for (int i = 0; i < 8; i++) ahb_read(R_RX, 32'h41 + i);
        ahb_read(R_STAT, 32'h0A);

`ifdef SPI_IRQ_EN
        // T6 RX-not-empty interrupt
        ahb_write(R_IRQEN, 32'h2);
        ahb_read(R_IRQEN, 32'h2);
        check("t6_irq_idle", IRQ, 0);
        ahb_write(R_TX, 32'h77);
        repeat (60) @(posedge HCLK);
        #1;
        check("t6_irq_set", IRQ, 1);
        ahb_read(R_RX, 32'h77);
        repeat (3) @(posedge HCLK);
        #1;
        check("t6_irq_clear", IRQ, 0);
`endif

        // Asynchronous reset in the middle of a byte
        ahb_write(R_CTRL, 32'h0403);
        ahb_write(R_TX, 32'h5A);
        t = 0;
        while (SPISCLKO !== 1'b1 && t < 500) begin @(negedge HCLK); t++; end
        check("rst_mid_sclk_seen", SPISCLKO, 1);
        #2;
        HRESETN = 1'b0;
        #1;
        check("rst_mid_sclk", SPISCLKO, 0);
        check("rst_mid_spiss", SPISS, 1);
        check("rst_mid_sdo", SPISDO, 0);
        repeat (2) @(negedge HCLK);
        HRESETN = 1'b1;
        ahb_read(R_CTRL, 32'h0400);
        ahb_read(R_STAT, 32'h0A);
        ahb_read(R_RX, 32'h0);

        t = 0;
        while (sb_q.size() != 0 && t < 20) begin @(negedge HCLK); t++; end
        check("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
